// File: rtl/scpad_types_pkg.sv
// Shared scratchpad types for the VC/backend request fan-in.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scpad_types_pkg;

  // Frontend VC channels plus the backend channel (the last one).
  localparam int SCPAD_NUM_VC_CH = 3;

  // Channel-id width; a single channel still gets one bit so vectors stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SCPAD_VC_ID_W = id_width(SCPAD_NUM_VC_CH);

  typedef logic [SCPAD_VC_ID_W-1:0] vc_id_t;

  typedef struct packed {
    logic   valid;
    vc_id_t id;
  } arb_tag_t;

endpackage

// File: rtl/scpad_tag_fifo.sv
// In-order tag FIFO: records which channel owns each outstanding SRAM request.
// Latency: push visible at head the cycle after; pop takes effect at the clock edge.
// Backpressure: push ignored when full, pop ignored when empty; callers gate on full/empty.
// Ports: clk/rst_n, push+push_id, pop, head_id (current oldest tag), full, empty, count.
module scpad_tag_fifo
  import scpad_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SCPAD_VC_ID_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_id,
  input  logic                   pop,
  output logic [W-1:0]           head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_id;
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_id = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/scpad_vc_arbiter.sv
// Round-robin fan-in of NUM_CH requesters onto one SRAM request port, with in-order response routing.
// Latency: accept -> sram_req_valid 1 cycle; SRAM response -> rsp_valid 0 cycles (combinational).
// Backpressure: no grant while sram_busy is high or DEPTH requests are outstanding.
// Ports: CLK/nRST; req_valid/req_data/req_ready per channel; sram_busy, sram_req_valid/data/id;
//        sram_rsp_valid/data in, rsp_valid (one-hot owner)/rsp_data out; inflight_cnt; err_unexpected_rsp (sticky).
// Build option: define SCPAD_ARB_BACKEND_PRIO_EN to give channel NUM_CH-1 (backend) strict priority.
module scpad_vc_arbiter
  import scpad_types_pkg::*;
#(
  parameter int NUM_CH = SCPAD_NUM_VC_CH,
  parameter int REQ_W  = 64,
  parameter int RSP_W  = 64,
  parameter int DEPTH  = 4,
  parameter int ID_W   = id_width(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*REQ_W-1:0] req_data,
  output logic [NUM_CH-1:0]       req_ready,
  input  logic                    sram_busy,
  output logic                    sram_req_valid,
  output logic [REQ_W-1:0]        sram_req_data,
  output logic [ID_W-1:0]         sram_req_id,
  input  logic                    sram_rsp_valid,
  input  logic [RSP_W-1:0]        sram_rsp_data,
  output logic [NUM_CH-1:0]       rsp_valid,
  output logic [RSP_W-1:0]        rsp_data,
  output logic [$clog2(DEPTH):0]  inflight_cnt,
  output logic                    err_unexpected_rsp
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant_found;
  logic            can_issue;
  logic            xfer;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] head_id;

  // Registered count only: a same-cycle pop never frees a slot for a grant.
  assign can_issue = !sram_busy && (int'(inflight_cnt) < DEPTH);

  // Search starts one past the last granted channel so it gets lowest priority next.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
`ifdef SCPAD_ARB_BACKEND_PRIO_EN
    if (req_valid[NUM_CH-1]) begin
      grant_found = 1'b1;
      grant_id    = ID_W'(NUM_CH - 1);
    end
`endif
  end

  assign xfer      = can_issue && grant_found;
  assign req_ready = xfer ? (NUM_CH'(1) << grant_id) : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr             <= '0;
      sram_req_valid     <= 1'b0;
      sram_req_data      <= '0;
      sram_req_id        <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      sram_req_valid <= xfer;
      if (xfer) begin
        sram_req_data <= req_data[grant_id*REQ_W +: REQ_W];
        sram_req_id   <= grant_id;
`ifdef SCPAD_ARB_BACKEND_PRIO_EN
        // Backend grants leave the frontend rotation where it was.
        if (grant_id != ID_W'(NUM_CH - 1)) rr_ptr <= grant_id;
`else
        rr_ptr <= grant_id;
`endif
      end
      if (sram_rsp_valid && fifo_empty) err_unexpected_rsp <= 1'b1;
    end
  end

  // Responses return in issue order, so the FIFO head always names the owner.
  assign pop       = sram_rsp_valid && !fifo_empty;
  assign rsp_valid = pop ? (NUM_CH'(1) << head_id) : '0;
  assign rsp_data  = pop ? sram_rsp_data : '0;

  scpad_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk     (CLK),
    .rst_n   (nRST),
    .push    (xfer),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (inflight_cnt)
  );

endmodule

// File: tb/tb_scpad_vc_arbiter.sv
// Bench for scpad_vc_arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: sram_busy driven both directed and randomly.
module tb_scpad_vc_arbiter;
  import scpad_types_pkg::*;

  localparam int NUM_CH = 3;
  localparam int REQ_W  = 64;
  localparam int RSP_W  = 64;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 2;
  localparam int CW     = 3;

  logic                    CLK;
  logic                    nRST;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*REQ_W-1:0] req_data;
  logic [NUM_CH-1:0]       req_ready;
  logic                    sram_busy;
  logic                    sram_req_valid;
  logic [REQ_W-1:0]        sram_req_data;
  logic [ID_W-1:0]         sram_req_id;
  logic                    sram_rsp_valid;
  logic [RSP_W-1:0]        sram_rsp_data;
  logic [NUM_CH-1:0]       rsp_valid;
  logic [RSP_W-1:0]        rsp_data;
  logic [CW-1:0]           inflight_cnt;
  logic                    err_unexpected_rsp;

  scpad_vc_arbiter #(
    .NUM_CH (NUM_CH),
    .REQ_W  (REQ_W),
    .RSP_W  (RSP_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .sram_busy          (sram_busy),
    .sram_req_valid     (sram_req_valid),
    .sram_req_data      (sram_req_data),
    .sram_req_id        (sram_req_id),
    .sram_rsp_valid     (sram_rsp_valid),
    .sram_rsp_data      (sram_rsp_data),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .inflight_cnt       (inflight_cnt),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: queue of owners of outstanding requests, last granted channel,
  // sticky error flag and the expected registered SRAM request.
  int          q[$];
  int          rr;
  bit          err_m;
  bit          exp_sv;
  logic [63:0] exp_sd;
  int          exp_sid;
  int          last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr         = 0;
    err_m      = 1'b0;
    exp_sv     = 1'b0;
    exp_sd     = '0;
    exp_sid    = 0;
    last_grant = -1;
  endtask

  // One cycle: drive at the falling edge, check just after, update the model at the rising edge.
  task automatic step(input logic [NUM_CH-1:0] v, input bit busy, input bit rv);
    int                g;
    bit                can;
    logic [NUM_CH-1:0] exp_rdy;
    logic [63:0]       pd;
    req_valid      = v;
    sram_busy      = busy;
    sram_rsp_valid = rv;
    for (int i = 0; i < NUM_CH; i++) req_data[i*REQ_W +: REQ_W] = {$urandom, $urandom};
    sram_rsp_data = {$urandom, $urandom};
    #1;
    can = !busy && (q.size() < DEPTH);
    g   = -1;
    if (can) begin
`ifdef SCPAD_ARB_BACKEND_PRIO_EN
      if (v[NUM_CH-1]) g = NUM_CH - 1;
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (rr + k) % NUM_CH;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (NUM_CH'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("inflight_cnt", inflight_cnt, q.size());
    chk("err_unexpected_rsp", err_unexpected_rsp, err_m);
    chk("sram_req_valid", sram_req_valid, exp_sv);
    if (exp_sv) begin
      chk("sram_req_data", sram_req_data, exp_sd);
      chk("sram_req_id", sram_req_id, exp_sid);
    end
    if (rv && q.size() > 0) begin
      chk("rsp_valid", rsp_valid, NUM_CH'(1) << q[0]);
      chk("rsp_data", rsp_data, sram_rsp_data);
    end else begin
      chk("rsp_valid_idle", rsp_valid, 0);
    end
    pd = '0;
    if (g >= 0) pd = req_data[g*REQ_W +: REQ_W];
    @(posedge CLK);
    if (rv) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1'b1;
    end
    if (g >= 0) begin
      q.push_back(g);
      exp_sv  = 1'b1;
      exp_sd  = pd;
      exp_sid = g;
`ifdef SCPAD_ARB_BACKEND_PRIO_EN
      if (g != NUM_CH - 1) rr = g;
`else
      rr = g;
`endif
    end else begin
      exp_sv = 1'b0;
    end
    last_grant = g;
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sram_req_valid"}, sram_req_valid, 0);
    chk({tag, "_sram_req_data"}, sram_req_data, 0);
    chk({tag, "_sram_req_id"}, sram_req_id, 0);
    chk({tag, "_inflight_cnt"}, inflight_cnt, 0);
    chk({tag, "_err"}, err_unexpected_rsp, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    nRST           = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    sram_busy      = 1'b0;
    sram_rsp_valid = 1'b0;
    sram_rsp_data  = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outputs("por");
    nRST = 1'b1;
    step('0, 1'b0, 1'b0);

    // All channels valid, each response two cycles after its grant.
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 1'b0, i >= 2);
`ifdef SCPAD_ARB_BACKEND_PRIO_EN
      chk("grant_order", last_grant, NUM_CH - 1);
`else
      chk("grant_order", last_grant, (i + 1) % NUM_CH);
`endif
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    // Backpressure holds off channel 1 until busy drops.
    for (int i = 0; i < 5; i++) begin
      step(3'b010, 1'b1, 1'b0);
      chk("busy_no_grant", last_grant, -1);
    end
    step(3'b010, 1'b0, 1'b0);
    chk("busy_release_grant", last_grant, 1);
    chk("busy_release_issue", sram_req_valid, 1);
    step('0, 1'b0, 1'b1);

    // Fill all DEPTH slots with no responses.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(3'b001, 1'b0, 1'b0);
      if (last_grant >= 0) n++;
    end
    chk("full_grants", n, DEPTH);
    chk("full_inflight", inflight_cnt, DEPTH);
    chk("full_ready", req_ready, 0);
    step(3'b001, 1'b0, 1'b1);
    chk("full_pop_no_grant", last_grant, -1);
    step(3'b001, 1'b0, 1'b0);
    chk("full_next_grant", last_grant, 0);
    for (int i = 0; i < DEPTH; i++) step('0, 1'b0, 1'b1);

    // Random traffic; responses only while something is outstanding.
    for (int i = 0; i < 400; i++) begin
      step(NUM_CH'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
           ($urandom_range(0, 9) < 4) && (q.size() > 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) if (q.size() > 0) step('0, 1'b0, 1'b1);

    // Response with nothing outstanding: sticky error.
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0);
    chk("err_sticky", err_unexpected_rsp, 1);

    // Asynchronous reset with requests in flight.
    for (int i = 0; i < 3; i++) step(3'b111, 1'b0, 1'b0);
    chk("pre_reset_inflight", inflight_cnt, 3);
    req_valid      = '0;
    sram_rsp_valid = 1'b0;
    nRST           = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    chk("post_reset_err", err_unexpected_rsp, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
